// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared memory-access encodings, FSM states and store-lane helper
package mem_pkg;

   localparam logic [1:0] SIZE_WORD = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_BYTE = 2'b10;
   localparam logic [1:0] SIZE_NONE = 2'b11;

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   // Replicate right-justified store data across every byte lane the access may hit
   function automatic logic [31:0] lane_replicate(input logic [31:0] wdata, input logic [1:0] size);
      logic [31:0] res;
      case (size)
         SIZE_BYTE: res = {4{wdata[7:0]}};
         SIZE_HALF: res = {2{wdata[15:0]}};
         default:   res = wdata;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/load_align_ext.sv
// rtl/load_align_ext.sv - load lane select with sign/zero extension
module load_align_ext
   import mem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   output logic [31:0] result
);

   logic [31:0] byte_sh;
   logic [31:0] half_sh;

   // Shift the addressed lane down to bit 0, then extend it to a full word
   always_comb begin
      byte_sh = rdata >> {addr, 3'b000};
      half_sh = rdata >> {addr[1], 4'b0000};
      case (size)
         SIZE_BYTE: result = is_unsigned ? {24'h0, byte_sh[7:0]}
                                         : {{24{byte_sh[7]}}, byte_sh[7:0]};
         SIZE_HALF: result = is_unsigned ? {16'h0, half_sh[15:0]}
                                         : {{16{half_sh[15]}}, half_sh[15:0]};
         default:   result = rdata;
      endcase
   end

endmodule

// File: rtl/dmem_seq.sv
// rtl/dmem_seq.sv - MEM-stage data-memory sequencer; DMEM_MISALIGN_TRAP_EN enables the misalign trap
module dmem_seq
   import mem_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int MAX_WAIT = 15
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              stall,
   output logic              resp_valid,
   output logic              resp_err,
   output logic [31:0]       resp_rdata,
   output logic              dmem_req,
   output logic              dmem_wr,
   output logic [1:0]        dmem_size,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [31:0]       dmem_wdata,
   input  logic [31:0]       dmem_rdata,
   input  logic              dmem_ready_n
);

   localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

   state_t            state;
   logic [7:0]        wait_cnt;
   logic              lat_unsigned;
   logic              accept;
   logic              misaligned;
   logic [ADDR_W-1:0] addr_aligned;
   logic [31:0]       load_data;

   // Request qualification, misalignment detection and address alignment
   always_comb begin
      accept     = (state == ST_IDLE) && req_valid && (req_size != SIZE_NONE);
      misaligned = ((req_size == SIZE_HALF) && req_addr[0]) ||
                   ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
      case (req_size)
         SIZE_HALF: addr_aligned = {req_addr[ADDR_W-1:1], 1'b0};
         SIZE_WORD: addr_aligned = {req_addr[ADDR_W-1:2], 2'b00};
         default:   addr_aligned = req_addr;
      endcase
      stall = (state == ST_REQ) || accept;
   end

   // Lane selection uses the already-aligned bus address
   load_align_ext u_align (
      .rdata       (dmem_rdata),
      .addr        (dmem_addr[1:0]),
      .size        (dmem_size),
      .is_unsigned (lat_unsigned),
      .result      (load_data)
   );

   // Sequencer FSM with registered bus and response outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         wait_cnt     <= 8'd0;
         lat_unsigned <= 1'b0;
         dmem_req     <= 1'b0;
         dmem_wr      <= 1'b0;
         dmem_size    <= SIZE_NONE;
         dmem_addr    <= '0;
         dmem_wdata   <= 32'h0;
         resp_valid   <= 1'b0;
         resp_err     <= 1'b0;
         resp_rdata   <= 32'h0;
      end else begin
         case (state)
            ST_IDLE: begin
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               resp_rdata <= 32'h0;
               if (accept) begin
                  lat_unsigned <= req_unsigned;
                  dmem_addr    <= addr_aligned;
                  dmem_wdata   <= lane_replicate(req_wdata, req_size);
                  wait_cnt     <= 8'd0;
`ifdef DMEM_MISALIGN_TRAP_EN
                  if (misaligned) begin
                     // Trap without touching the bus
                     state      <= ST_DONE;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                  end else begin
                     state     <= ST_REQ;
                     dmem_req  <= 1'b1;
                     dmem_wr   <= req_write;
                     dmem_size <= req_size;
                  end
`else
                  // Misaligned accesses simply run with the low bits cleared
                  state     <= ST_REQ;
                  dmem_req  <= 1'b1;
                  dmem_wr   <= req_write;
                  dmem_size <= req_size;
`endif
               end
            end
            ST_REQ: begin
               if (!dmem_ready_n) begin
                  state      <= ST_DONE;
                  dmem_req   <= 1'b0;
                  dmem_wr    <= 1'b0;
                  dmem_size  <= SIZE_NONE;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_rdata <= dmem_wr ? 32'h0 : load_data;
               end else if (wait_cnt == WAIT_LIMIT) begin
                  state      <= ST_DONE;
                  dmem_req   <= 1'b0;
                  dmem_wr    <= 1'b0;
                  dmem_size  <= SIZE_NONE;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
                  resp_rdata <= 32'h0;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            ST_DONE: begin
               state      <= ST_IDLE;
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               resp_rdata <= 32'h0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_seq.sv
// tb/tb_dmem_seq.sv - self-checking bench for dmem_seq against a behavioural access model
module tb_dmem_seq;

   localparam int ADDR_W   = 32;
   localparam int MAX_WAIT = 15;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_valid;
   logic              req_write;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              stall;
   logic              resp_valid;
   logic              resp_err;
   logic [31:0]       resp_rdata;
   logic              dmem_req;
   logic              dmem_wr;
   logic [1:0]        dmem_size;
   logic [ADDR_W-1:0] dmem_addr;
   logic [31:0]       dmem_wdata;
   logic [31:0]       dmem_rdata;
   logic              dmem_ready_n;

   int checks = 0;
   int errors = 0;

   dmem_seq #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_write    (req_write),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .stall        (stall),
      .resp_valid   (resp_valid),
      .resp_err     (resp_err),
      .resp_rdata   (resp_rdata),
      .dmem_req     (dmem_req),
      .dmem_wr      (dmem_wr),
      .dmem_size    (dmem_size),
      .dmem_addr    (dmem_addr),
      .dmem_wdata   (dmem_wdata),
      .dmem_rdata   (dmem_rdata),
      .dmem_ready_n (dmem_ready_n)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Loaded value as the ISA defines it: pick the addressed byte/half, then extend
   function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [1:0] a,
                                            input logic [1:0] sz, input logic uns);
      longint v;
      if (sz == 2'b10) begin
         v = longint'((rd >> (8 * int'(a))) & 32'hFF);
         if (!uns && v > 127) v = v - 256;
      end else if (sz == 2'b01) begin
         v = longint'((rd >> (16 * int'(a[1]))) & 32'hFFFF);
         if (!uns && v > 32767) v = v - 65536;
      end else begin
         v = longint'(rd);
      end
      return v[31:0];
   endfunction

   // One complete access: ready_n held high for nwait REQ cycles, then low
   task automatic access(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input int nwait);
      logic [31:0] eff_addr;
      logic [31:0] exp_wdata;
      logic [31:0] exp_rdata;
      logic        misal;
      logic        trap;
      logic        exp_err;
      int          exp_cycle;
      int          n;
      bit          got;
      misal = (sz == 2'b01 && addr[0]) || (sz == 2'b00 && addr[1:0] != 2'b00);
`ifdef DMEM_MISALIGN_TRAP_EN
      trap = misal;
`else
      trap = 1'b0;
`endif
      eff_addr = (sz == 2'b01) ? (addr & ~32'd1) : (sz == 2'b00) ? (addr & ~32'd3) : addr;
      exp_wdata = (sz == 2'b10) ? {4{wd[7:0]}} : (sz == 2'b01) ? {2{wd[15:0]}} : wd;
      if (trap) begin
         exp_cycle = 1; exp_err = 1'b1; exp_rdata = 32'h0;
      end else if (nwait > MAX_WAIT) begin
         exp_cycle = MAX_WAIT + 2; exp_err = 1'b1; exp_rdata = 32'h0;
      end else begin
         exp_cycle = nwait + 2; exp_err = 1'b0;
         exp_rdata = wr ? 32'h0 : ref_load(rd, eff_addr[1:0], sz, uns);
      end
      req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
      req_addr = addr; req_wdata = wd;
      dmem_ready_n = 1'b1; dmem_rdata = $urandom;
      #1;
      chk("stall_accept", 32'(stall), 32'd1);
      cyc();
      n = 1; got = 0;
      while (!got && n < exp_cycle + 4) begin
         if (resp_valid) begin
            got = 1;
            chk("resp_cycle", n, exp_cycle);
            chk("resp_err", 32'(resp_err), 32'(exp_err));
            chk("resp_rdata", resp_rdata, exp_rdata);
            chk("stall_done", 32'(stall), 32'd0);
            req_valid = 1'b0;
         end else begin
            chk("dmem_req", 32'(dmem_req), 32'd1);
            chk("dmem_addr", dmem_addr, eff_addr);
            chk("dmem_size", 32'(dmem_size), 32'(sz));
            chk("dmem_wr", 32'(dmem_wr), 32'(wr));
            chk("stall_req", 32'(stall), 32'd1);
            if (wr) chk("dmem_wdata", dmem_wdata, exp_wdata);
            if (n - 1 < nwait) begin
               dmem_ready_n = 1'b1; dmem_rdata = $urandom;
            end else begin
               dmem_ready_n = 1'b0; dmem_rdata = rd;
            end
         end
         cyc();
         n++;
      end
      chk("resp_seen", 32'(got), 32'd1);
      req_valid = 1'b0; dmem_ready_n = 1'b1;
      chk("idle_dmem_req", 32'(dmem_req), 32'd0);
      chk("idle_resp_valid", 32'(resp_valid), 32'd0);
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b11;
      req_unsigned = 1'b0; req_addr = '0; req_wdata = 32'h0;
      dmem_rdata = 32'h0; dmem_ready_n = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_dmem_req", 32'(dmem_req), 32'd0);
      chk("rst_dmem_wr", 32'(dmem_wr), 32'd0);
      chk("rst_dmem_size", 32'(dmem_size), 32'd3);
      chk("rst_dmem_addr", dmem_addr, 32'h0);
      chk("rst_dmem_wdata", dmem_wdata, 32'h0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'h0);
      rst = 1'b0;
      cyc();

      // Directed cases from the access rules
      access(1'b0, 2'b10, 1'b0, 32'h0000_1003, 32'h0, 32'h8011_2233, 0);
      access(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 3);
      access(1'b0, 2'b00, 1'b0, 32'h0000_3000, 32'h0, 32'hDEAD_BEEF, 1000);
      access(1'b0, 2'b01, 1'b1, 32'h0000_4001, 32'h0, 32'h1234_8001, 0);
      access(1'b0, 2'b01, 1'b0, 32'h0000_4002, 32'h0, 32'h8001_1234, 1);
      access(1'b1, 2'b10, 1'b0, 32'h0000_4001, 32'h0000_00C5, 32'h0, 0);
      access(1'b0, 2'b00, 1'b0, 32'h0000_5004, 32'h0, 32'hCAFE_F00D, MAX_WAIT);

      // Reset while waiting in REQ abandons the access silently
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 32'h0000_6000; dmem_ready_n = 1'b1;
      cyc();
      cyc();
      cyc();
      chk("pre_rst_dmem_req", 32'(dmem_req), 32'd1);
      rst = 1'b1;
      cyc();
      rst = 1'b0; req_valid = 1'b0;
      #1;
      chk("post_rst_dmem_req", 32'(dmem_req), 32'd0);
      chk("post_rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("post_rst_stall", 32'(stall), 32'd0);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("post_rst_quiet", 32'(resp_valid), 32'd0);
      end
      access(1'b0, 2'b10, 1'b1, 32'h0000_6001, 32'h0, 32'h0000_9900, 0);

      // Size 11 is never accepted
      req_valid = 1'b1; req_size = 2'b11; req_addr = 32'h0000_7000;
      #1;
      chk("none_stall", 32'(stall), 32'd0);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("none_dmem_req", 32'(dmem_req), 32'd0);
         chk("none_resp_valid", 32'(resp_valid), 32'd0);
      end
      req_valid = 1'b0;
      cyc();

      // Randomised accesses, mostly short waits with occasional timeouts
      for (int i = 0; i < 25; i++) begin
         int nw;
         nw = ($urandom_range(0, 7) == 0) ? 40 : int'($urandom_range(0, 4));
         access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                $urandom, $urandom, $urandom, nw);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dmem_seq.md
# dmem_seq

Data-memory access sequencer for the MEM stage of the RV32I pipeline. It accepts one load/store request at a time from the pipeline and drives the single-ported data-memory bus through its `ready_n` wait-state handshake. It stalls the pipeline while the access is outstanding, and returns a response with aligned, sign- or zero-extended load data. It also replicates store data across byte lanes and bounds every access with a wait-state timeout.

## Interface
Parameters:
- `ADDR_W`, 32: address width.
- `MAX_WAIT`, 15: ready_n-high cycles tolerated in REQ before a bus error; range 1..255.

Ports:
- `clk`  in  1  the only clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  MEM stage holds a load/store; held until the response cycle.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 word, 01 half, 10 byte, 11 none; 11 is never accepted.
- `req_unsigned`  in  1  funct3[2]; zero-extend the load.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `stall`  out  1  freeze the pipeline.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_err`  out  1  qualified by `resp_valid`; timeout or misalign trap.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `dmem_req`  out  1  access request to the bus.
- `dmem_wr`  out  1  write enable.
- `dmem_size`  out  2  same encoding as `req_size`.
- `dmem_addr`  out  ADDR_W  byte address to the bus.
- `dmem_wdata`  out  32  lane-replicated store data.
- `dmem_rdata`  in  32  raw word from memory.
- `dmem_ready_n`  in  1  0 = access completes this cycle, 1 = wait.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - `req_valid` with size != 11 latches addr, size, write, unsigned and wdata.
  - Aligned request (or trap disabled) → REQ.
  - Misaligned request with trap enabled → DONE with the error flag set.
- REQ:
  - `dmem_req` = 1; all `dmem_*` outputs driven from the latched registers.
  - `dmem_ready_n` = 0: the access completes; `dmem_rdata` is captured in that same cycle; → DONE.
  - Otherwise the wait counter increments.
  - Counter == `MAX_WAIT` with `dmem_ready_n` still 1: → DONE with err = 1; `dmem_req` drops.
- DONE: `resp_valid` = 1 → IDLE unconditionally. A new request is not accepted in DONE.
- `stall` = (state == REQ) | (state == IDLE & `req_valid` & size != 11). It is 0 in DONE, so the pipeline advances on the response cycle.
- Misaligned: half with addr[0] = 1; word with addr[1:0] != 0.
- Store lanes:
  - Byte: replicate wdata[7:0] to all four lanes.
  - Half: replicate wdata[15:0] to both halves.
  - Word: pass through.
- Load extraction:
  - Byte: lane addr[1:0].
  - Half: lane addr[1].
  - Shift right, then sign- or zero-extend to 32 bits per `req_unsigned`.
- Wait counter: 8 bits, cleared on entry to REQ.

## Timing
- Reset values:
  - FSM: IDLE; counter 0.
  - `dmem_req`, `dmem_wr`, `resp_valid`, `resp_err`: 0.
  - `dmem_size`: 11.
  - `dmem_addr`, `dmem_wdata`, `resp_rdata`: 0.
  - `stall`: combinational; it follows `req_valid` in IDLE.
- Zero-wait access:
  - Request seen in cycle 0.
  - REQ in cycle 1 with `dmem_ready_n` = 0.
  - `resp_valid` in cycle 2.
  - Latency 2; +1 per wait cycle.
- Timeout: `resp_valid` with err arrives `MAX_WAIT` + 2 cycles after acceptance.
- Misalign trap: `resp_valid` with err in cycle 1; `dmem_req` is never asserted.
- Back-to-back requests: one IDLE bubble between the DONE of the first and REQ of the second.
- `rst` in any state: IDLE next cycle; `dmem_req` = 0 next cycle; the in-flight access is abandoned with no response.
- `dmem_ready_n` is ignored outside REQ.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined:
  - Misaligned requests complete via DONE with `resp_err` = 1 and no bus access.
- Undefined:
  - Misaligned requests proceed with low address bits cleared (half: addr[0] = 0; word: addr[1:0] = 0) on `dmem_addr` and for lane selection.
  - `resp_err` comes only from timeout.

## Structure
- Shared package `mem_pkg`:
  - Size encodings SIZE_WORD / SIZE_HALF / SIZE_BYTE / SIZE_NONE, reused by the existing memory controller.
  - FSM state enum.
  - Opcode constants LOAD = 0000011, STORE = 0100011.
- Sub-module `load_align_ext`: combinational lane select plus sign/zero extension. Inputs: rdata, addr[1:0], size, unsigned; output: 32-bit result.

## Test plan
- Load byte, addr 0x...3, rdata 0x80112233, signed, ready_n = 0 immediately → cycle 2 `resp_valid`, rdata 0xFFFFFF80; `stall` 1 in cycles 0–1.
- Store half, addr 0x...2, wdata 0x0000ABCD, ready_n high 3 cycles → `dmem_wdata` 0xABCDABCD, `dmem_size` 01, `dmem_wr` 1 for 4 cycles; response at cycle 5.
- Load word, ready_n stuck at 1, `MAX_WAIT` = 15 → `resp_valid` with `resp_err` = 1, rdata 0, at cycle 17; `dmem_req` low afterwards.
- Load half, addr 0x...1:
  - With `DMEM_MISALIGN_TRAP_EN`: error at cycle 1, no `dmem_req`.
  - Without it: `dmem_addr` low bit 0; the unsigned load of 0x1234_8001 returns 0x00008001.
- `rst` asserted in REQ after 2 wait cycles → IDLE, `dmem_req` 0, no `resp_valid`; the next request behaves normally.
- `req_valid` with size 11 → `stall` 0, no `dmem_req`, no response.
